// File: rtl/viterbi_stream_decoder.sv
// -----------------------------------------------------------------------------
// viterbi_stream_decoder
//
// Hard-decision Viterbi decoder for the K=3, rate-1/2 convolutional code with
// generators g0=111, g1=101. One block of N_BITS symbol pairs is accepted per
// input handshake. The add-compare-select (ACS) step handles one trellis stage
// per cycle, and a full traceback then recovers the N_BITS decoded bits, which
// are offered on an output handshake.
//
// Parameters
//   N_BITS  decoded bits per block (>=3); data_in is 2*N_BITS wide
//   PM_W    path-metric width (>=4); metrics saturate at 2^PM_W-1
//
// Ports
//   clk        in   1         single clock, rising edge
//   rst        in   1         synchronous, active-high reset (aborts any block)
//   data_in    in   2*N_BITS  coded block; pair i = data_in[2i+1:2i] = {c0,c1},
//                             pair 0 earliest in time
//   in_valid   in   1         data_in valid
//   in_ready   out  1         decoder idle and able to accept a block
//   data_out   out  N_BITS    decoded bits; data_out[i] is the bit for pair i
//   out_valid  out  1         data_out valid, held until accepted
//   out_ready  in   1         downstream accepts data_out
//
// Build option
//   TAIL_TERM_EN  when defined, blocks are assumed zero-flushed and traceback
//                 always starts from state 00 (no final metric compare).
//                 When undefined, traceback starts from the state with the
//                 smallest final path metric, with ties going to the lowest index.
//
// Trellis convention: state s = {u[t-1], u[t-2]}; next state = {u, s[1]};
// code bits c0 = u^s[1]^s[0], c1 = u^s[0].
// -----------------------------------------------------------------------------
module viterbi_stream_decoder #(
    parameter int N_BITS = 8,
    parameter int PM_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*N_BITS-1:0]   data_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N_BITS-1:0]     data_out,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int              T_W    = $clog2(N_BITS);
    localparam logic [PM_W-1:0] PM_MAX = '1;
    localparam logic [T_W-1:0]  T_LAST = T_W'(N_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACS  = 2'd1,
        TB   = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [2*N_BITS-1:0] block;
    logic [T_W-1:0]      t_cnt;
    logic [PM_W-1:0]     pm [4];
    logic [3:0]          surv [N_BITS];
    logic [1:0]          cur;
    logic                accept;

    // Saturating add of a branch metric onto a path metric; never wraps.
    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                                input logic [1:0]      b);
        logic [PM_W:0] sum;
        sum = {1'b0, a} + {{(PM_W - 1){1'b0}}, b};
        if (sum[PM_W]) begin
            return PM_MAX;
        end
        return sum[PM_W-1:0];
    endfunction

    // Expected {c0,c1} for input bit u leaving state {p1,p0}.
    function automatic logic [1:0] code_bits(input logic u, input logic p1,
                                             input logic p0);
        return {u ^ p1 ^ p0, u ^ p0};
    endfunction

    // Hamming distance between received and expected pair (0..2).
    function automatic logic [1:0] branch_metric(input logic [1:0] rx,
                                                 input logic [1:0] ex);
        logic [1:0] diff;
        diff = rx ^ ex;
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ACS;
                end
            end
            ACS: begin
                if (t_cnt == T_LAST) begin
                    state_next = TB;
                end
            end
            TB: begin
                if (t_cnt == '0) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                // IDLE is always visited before the next block is taken.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Add-compare-select for the current stage
    // ------------------------------------------------------------------
    logic [1:0]      pair;
    logic [PM_W-1:0] cand0 [4];
    logic [PM_W-1:0] cand1 [4];
    logic [PM_W-1:0] pm_acs [4];
    logic [PM_W-1:0] pm_norm [4];
    logic [PM_W-1:0] pm_min;
    logic [3:0]      dec;
    logic [1:0]      tb_start;

    always_comb begin
        pair = block[2*t_cnt +: 2];
        dec  = '0;
        for (int ns = 0; ns < 4; ns++) begin
            // Predecessors of {u,p1} are {p1,0} and {p1,1}.
            cand0[ns] = sat_add(pm[{ns[0], 1'b0}],
                                branch_metric(pair, code_bits(ns[1], ns[0], 1'b0)));
            cand1[ns] = sat_add(pm[{ns[0], 1'b1}],
                                branch_metric(pair, code_bits(ns[1], ns[0], 1'b1)));
            // Strict compare: a tie keeps the predecessor with s[0]=0.
            if (cand1[ns] < cand0[ns]) begin
                dec[ns]    = 1'b1;
                pm_acs[ns] = cand1[ns];
            end else begin
                pm_acs[ns] = cand0[ns];
            end
        end
        pm_min = pm_acs[0];
        for (int i = 1; i < 4; i++) begin
            if (pm_acs[i] < pm_min) begin
                pm_min = pm_acs[i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            pm_norm[i] = pm_acs[i] - pm_min;
        end
    end

`ifdef TAIL_TERM_EN
    assign tb_start = 2'b00;
`else
    // After normalisation the best state is the lowest index whose metric is 0.
    always_comb begin
        tb_start = 2'b00;
        for (int i = 3; i >= 0; i--) begin
            if (pm_norm[i] == '0) begin
                tb_start = 2'(i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Traceback step
    // ------------------------------------------------------------------
    logic       surv_bit;
    logic [1:0] prev_state;

    always_comb begin
        surv_bit   = surv[t_cnt][cur];
        prev_state = {cur[0], surv_bit};
    end

    // ------------------------------------------------------------------
    // Block buffer and survivor memory (contents need no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            block <= data_in;
        end
        if (state == ACS) begin
            surv[t_cnt] <= dec;
        end
    end

    // ------------------------------------------------------------------
    // Metrics, stage counter, traceback state and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            t_cnt    <= '0;
            cur      <= '0;
            data_out <= '0;
            pm[0]    <= '0;
            for (int i = 1; i < 4; i++) begin
                pm[i] <= PM_MAX;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Encoder is known to start in state 00.
                        t_cnt <= '0;
                        pm[0] <= '0;
                        for (int i = 1; i < 4; i++) begin
                            pm[i] <= PM_MAX;
                        end
                    end
                end
                ACS: begin
                    for (int i = 0; i < 4; i++) begin
                        pm[i] <= pm_norm[i];
                    end
                    if (t_cnt == T_LAST) begin
                        // t_cnt stays at the last stage, where traceback begins.
                        cur <= tb_start;
                    end else begin
                        t_cnt <= t_cnt + T_W'(1);
                    end
                end
                TB: begin
                    data_out[t_cnt] <= cur[1];
                    cur             <= prev_state;
                    if (t_cnt != '0) begin
                        t_cnt <= t_cnt - T_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
